// File: rtl/memory_port_arbiter_pkg.sv
// Shared types for the memory port arbiter.
//   owner_e     : which requester holds the memory bus (fetch or data path)
//   arb_state_e : arbiter FSM state encoding
//   INSTR_SEL   : byte enables driven for instruction fetches
//   rr_other()  : the requester that did not win last time
package memory_port_arbiter_pkg;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  localparam logic [3:0] INSTR_SEL = 4'hF;

  function automatic owner_e rr_other(input owner_e last);
    return (last == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin grant with a fixed-priority override.
// Purely combinational; the caller owns the last-grant register.
// Ports:
//   req_i       [1:0] request vector, indexed by owner_e value
//   last_i            requester granted most recently
//   prio_en_i         1: a tie always goes to prio_sel_i
//   prio_sel_i        requester favoured when prio_en_i=1
//   gnt_valid_o       at least one request present
//   gnt_o             granted requester (meaningful when gnt_valid_o=1)
module arb_rr2
  import memory_port_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_e     last_i,
  input  logic       prio_en_i,
  input  owner_e     prio_sel_i,
  output logic       gnt_valid_o,
  output owner_e     gnt_o
);

  always_comb begin
    gnt_valid_o = |req_i;
    gnt_o       = OWN_INSTR;
    if (req_i == 2'b11) begin
      gnt_o = prio_en_i ? prio_sel_i : rr_other(last_i);
    end else if (req_i[OWN_DATA]) begin
      gnt_o = OWN_DATA;
    end else begin
      gnt_o = OWN_INSTR;
    end
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one memory bus between instruction fetch (stb/ack) and the data
// path (Wishbone cyc/stb). One transfer in flight, round-robin or
// data-priority on ties, per-transfer timeout with an error pulse.
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   instr_addr/instr_stb     fetch request (level, held until ack/err)
//   instr/instr_ack/instr_err fetch response
//   wb_cyc/wb_stb/wb_wr_en/wb_addr/wb_wr_data/wb_wr_sel  data request
//   wb_ack/wb_err/wb_stall/wb_rd_data                    data response
//   m_cyc/m_stb/m_wr_en/m_addr/m_wr_data/m_wr_sel        memory request
//   m_ack/m_stall/m_rd_data                              memory response
//
// state    | meaning
// ARB_IDLE | no transfer; arbitrate and latch the winner's request
// ARB_REQ  | m_stb asserted, waiting for memory to drop m_stall
// ARB_WAIT | request accepted, counting cycles until m_ack or timeout
module memory_port_arbiter
  import memory_port_arbiter_pkg::*;
#(
  parameter bit          DATA_PRIORITY = 1'b0,
  parameter int unsigned TIMEOUT       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_addr,
  input  logic        instr_stb,
  output logic [31:0] instr,
  output logic        instr_ack,
  output logic        instr_err,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_wr_en,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_wr_data,
  input  logic [3:0]  wb_wr_sel,
  output logic        wb_ack,
  output logic        wb_err,
  output logic        wb_stall,
  output logic [31:0] wb_rd_data,
  output logic        m_cyc,
  output logic        m_stb,
  output logic        m_wr_en,
  output logic [31:0] m_addr,
  output logic [31:0] m_wr_data,
  output logic [3:0]  m_wr_sel,
  input  logic        m_ack,
  input  logic        m_stall,
  input  logic [31:0] m_rd_data
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  owner_e           owner_q, owner_d;
  owner_e           last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             m_cyc_q, m_cyc_d;
  logic             m_stb_q, m_stb_d;
  logic             m_wr_en_q, m_wr_en_d;
  logic [31:0]      m_addr_q, m_addr_d;
  logic [31:0]      m_wr_data_q, m_wr_data_d;
  logic [3:0]       m_wr_sel_q, m_wr_sel_d;
  logic             ierr_q, ierr_d;
  logic             derr_q, derr_d;

  logic [1:0]       pend;
  logic             gnt_valid;
  owner_e           gnt;
  logic             xfer_done;

  // A requester whose error pulse is showing this cycle still has its
  // request up (it reacts to the pulse at the next edge); masking it keeps
  // the timed-out request from being granted a second time.
  assign pend[OWN_INSTR] = instr_stb & ~ierr_q;
  assign pend[OWN_DATA]  = wb_cyc & wb_stb & ~derr_q;

  arb_rr2 u_arb (
    .req_i       (pend),
    .last_i      (last_q),
    .prio_en_i   (DATA_PRIORITY),
    .prio_sel_i  (OWN_DATA),
    .gnt_valid_o (gnt_valid),
    .gnt_o       (gnt)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    m_cyc_d     = m_cyc_q;
    m_stb_d     = m_stb_q;
    m_wr_en_d   = m_wr_en_q;
    m_addr_d    = m_addr_q;
    m_wr_data_d = m_wr_data_q;
    m_wr_sel_d  = m_wr_sel_q;
    ierr_d      = 1'b0;
    derr_d      = 1'b0;
    xfer_done   = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt;
          last_d  = gnt;
          m_cyc_d = 1'b1;
          m_stb_d = 1'b1;
          if (gnt == OWN_DATA) begin
            m_wr_en_d   = wb_wr_en;
            m_addr_d    = wb_addr;
            m_wr_data_d = wb_wr_data;
            m_wr_sel_d  = wb_wr_sel;
          end else begin
            m_wr_en_d   = 1'b0;
            m_addr_d    = instr_addr;
            m_wr_data_d = 32'h0;
            m_wr_sel_d  = INSTR_SEL;
          end
          state_d = ARB_REQ;
        end
      end

      ARB_REQ: begin
        if (!m_stall) begin
          m_stb_d = 1'b0;
          cnt_d   = '0;
          // Memory may answer in the accept cycle itself.
          if (m_ack) begin
            xfer_done = 1'b1;
            m_cyc_d   = 1'b0;
            state_d   = ARB_IDLE;
          end else begin
            state_d = ARB_WAIT;
          end
        end
      end

      ARB_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (m_ack) begin
          xfer_done = 1'b1;
          m_cyc_d   = 1'b0;
          state_d   = ARB_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          m_cyc_d = 1'b0;
          state_d = ARB_IDLE;
          if (owner_q == OWN_DATA) derr_d = 1'b1;
          else                     ierr_d = 1'b1;
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_INSTR;
      last_q      <= OWN_INSTR;
      cnt_q       <= '0;
      m_cyc_q     <= 1'b0;
      m_stb_q     <= 1'b0;
      m_wr_en_q   <= 1'b0;
      m_addr_q    <= 32'h0;
      m_wr_data_q <= 32'h0;
      m_wr_sel_q  <= 4'h0;
      ierr_q      <= 1'b0;
      derr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      m_cyc_q     <= m_cyc_d;
      m_stb_q     <= m_stb_d;
      m_wr_en_q   <= m_wr_en_d;
      m_addr_q    <= m_addr_d;
      m_wr_data_q <= m_wr_data_d;
      m_wr_sel_q  <= m_wr_sel_d;
      ierr_q      <= ierr_d;
      derr_q      <= derr_d;
    end
  end

  // Ack and read data are a combinational pass-through of m_ack to the
  // owner. A data master that dropped wb_cyc mid-transfer gets no ack.
  assign instr_ack  = xfer_done & (owner_q == OWN_INSTR);
  assign instr      = instr_ack ? m_rd_data : 32'h0;
  assign wb_ack     = xfer_done & (owner_q == OWN_DATA) & wb_cyc;
  assign wb_rd_data = wb_ack ? m_rd_data : 32'h0;
  assign instr_err  = ierr_q;
  assign wb_err     = derr_q;
  assign wb_stall   = !((state_q == ARB_IDLE) && gnt_valid && (gnt == OWN_DATA));

  assign m_cyc     = m_cyc_q;
  assign m_stb     = m_stb_q;
  assign m_wr_en   = m_wr_en_q;
  assign m_addr    = m_addr_q;
  assign m_wr_data = m_wr_data_q;
  assign m_wr_sel  = m_wr_sel_q;

endmodule
